// File: rtl/sqrt_issue_arb.sv
// Round-robin issue arbiter sharing one fp16 sqrt pipeline between NUM_REQ requesters.
// An in-order tag FIFO returns each result to its issuer; a small FSM gates p_enable.
module sqrt_issue_arb #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int IDLE_CYCLES  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [16*NUM_REQ-1:0]               req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                p_enable,
    output logic                                p_valid,
    output logic [15:0]                         p_data,
    input  logic                                p_res_valid,
    input  logic [15:0]                         p_res_data,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [15:0]                         rsp_data,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
    output logic                                err_underflow
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_INFLIGHT + 1);
    localparam int PW  = $clog2(MAX_INFLIGHT);
    localparam int IW  = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAKE, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [IW-1:0]      idle_cnt_q, idle_cnt_d;
    logic               p_valid_q, p_valid_d;
    logic [15:0]        p_data_q, p_data_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [15:0]        rsp_data_q, rsp_data_d;
    logic               err_q, err_d;

    logic [IDW-1:0]     tag_mem [MAX_INFLIGHT];
    logic [IDW-1:0]     head;
    logic [IDW-1:0]     winner;
    logic [IDW:0]       cand;
    logic               found;
    logic               credit;
    logic               grant_en;
    logic               pop;
    logic               idle;

    // Credit only looks at registered state, keeping p_res_valid out of the ready path.
    assign credit   = (inflight_q < CW'(MAX_INFLIGHT));
    assign grant_en = (state_q == ST_RUN) && credit && found;
    assign pop      = p_res_valid && (inflight_q != '0);
    assign head     = tag_mem[rd_ptr_q];
    assign idle     = !(|req_valid) && (inflight_q == '0) && !p_res_valid;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (winner == IDW'(gi));
        end
    endgenerate

    always_comb begin
        p_valid_d   = grant_en;
        p_data_d    = p_data_q;
        rr_d        = rr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        inflight_d  = inflight_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q || (p_res_valid && (inflight_q == '0));
        if (grant_en) begin
            p_data_d = req_data[16*int'(winner) +: 16];
            rr_d     = (winner == IDW'(NUM_REQ-1)) ? '0 : winner + IDW'(1);
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d          = rd_ptr_q + PW'(1);
            rsp_valid_d[head] = 1'b1;
            rsp_data_d        = p_res_data;
        end
        case ({grant_en, pop})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        p_enable   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                p_enable = 1'b0;
                if (|req_valid) state_d = ST_WAKE;
            end
            ST_WAKE: state_d = ST_RUN;
            ST_RUN: begin
                // Leaving RUN needs inflight==0, so nothing is stranded mid-pipeline.
                if (idle) begin
                    if (idle_cnt_q == IW'(IDLE_CYCLES-1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                p_enable = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            inflight_q  <= '0;
            idle_cnt_q  <= '0;
            p_valid_q   <= 1'b0;
            p_data_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            inflight_q  <= inflight_d;
            idle_cnt_q  <= idle_cnt_d;
            p_valid_q   <= p_valid_d;
            p_data_q    <= p_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    // Tag storage needs no reset: emptiness is tracked by the pointers and inflight.
    always_ff @(posedge clk) begin
        if (grant_en) begin
            tag_mem[wr_ptr_q] <= winner;
        end
    end

    assign p_valid       = p_valid_q;
    assign p_data        = p_data_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign inflight      = inflight_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_sqrt_issue_arb.sv
// Directed bench for sqrt_issue_arb; the bench itself plays the sqrt pipeline,
// returning hand-computed fp16 square roots in issue order.
module tb_sqrt_issue_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        p_enable;
    logic        p_valid;
    logic [15:0] p_data;
    logic        p_res_valid;
    logic [15:0] p_res_data;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic [3:0]  inflight;
    logic        err_underflow;

    int total  = 0;
    int passed = 0;

    // Operands 1.0, 4.0, 9.0, 16.0 and their square roots 1.0, 2.0, 3.0, 4.0.
    logic [15:0] op_of   [4] = '{16'h3C00, 16'h4400, 16'h4880, 16'h4C00};
    logic [15:0] sqrt_of [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    int          order   [8] = '{2, 3, 0, 1, 2, 3, 0, 1};
    int          rest    [7] = '{0, 1, 2, 3, 0, 1, 2};

    always #5 clk = ~clk;

    sqrt_issue_arb #(.NUM_REQ(4), .MAX_INFLIGHT(8), .IDLE_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .p_enable(p_enable), .p_valid(p_valid), .p_data(p_data),
        .p_res_valid(p_res_valid), .p_res_data(p_res_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inflight(inflight), .err_underflow(err_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_pen"},   32'(p_enable), 32'h0);
        check({tag, "_pval"},  32'(p_valid), 32'h0);
        check({tag, "_pdata"}, 32'(p_data), 32'h0);
        check({tag, "_rval"},  32'(rsp_valid), 32'h0);
        check({tag, "_rdata"}, 32'(rsp_data), 32'h0);
        check({tag, "_infl"},  32'(inflight), 32'h0);
        check({tag, "_err"},   32'(err_underflow), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; p_res_valid = 1'b0; p_res_data = '0;
        #1;
        check_all_zero("reset");
        tick(); tick();
        rst = 1'b0;
        tick();
        check("idle_pen", 32'(p_enable), 32'h0);

        // Single request from requester 1
        req_valid = 4'b0010;
        req_data[31:16] = 16'h4400;
        #1;
        check("idle_nogrant", 32'(req_ready), 32'h0);
        tick();
        check("wake_pen", 32'(p_enable), 32'h1);
        check("wake_nogrant", 32'(req_ready), 32'h0);
        tick();
        check("run_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        check("issue1_pval", 32'(p_valid), 32'h1);
        check("issue1_pdata", 32'(p_data), 32'h4400);
        check("issue1_infl", 32'(inflight), 32'h1);
        tick();
        check("issue1_pval0", 32'(p_valid), 32'h0);
        check("issue1_hold", 32'(p_data), 32'h4400);
        p_res_valid = 1'b1; p_res_data = 16'h4000;
        tick();
        p_res_valid = 1'b0;
        check("rsp1_val", 32'(rsp_valid), 32'h2);
        check("rsp1_data", 32'(rsp_data), 32'h4000);
        check("rsp1_infl", 32'(inflight), 32'h0);
        tick();
        check("rsp1_pulse", 32'(rsp_valid), 32'h0);

        // All requesters valid: pointer sits at 2 after the first grant
        req_data  = {op_of[3], op_of[2], op_of[1], op_of[0]};
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << order[k]));
            tick();
            check($sformatf("rr_pval%0d", k), 32'(p_valid), 32'h1);
            check($sformatf("rr_pdata%0d", k), 32'(p_data), 32'(op_of[order[k]]));
        end
        #1;
        check("credit_ready", 32'(req_ready), 32'h0);
        check("credit_infl", 32'(inflight), 32'h8);

        // Result while full: no grant that cycle, one grant after release
        p_res_valid = 1'b1; p_res_data = sqrt_of[order[0]];
        #1;
        check("full_res_ready", 32'(req_ready), 32'h0);
        tick();
        check("full_rsp_val", 32'(rsp_valid), 32'(1 << order[0]));
        check("full_rsp_data", 32'(rsp_data), 32'(sqrt_of[order[0]]));
        check("full_infl7", 32'(inflight), 32'h7);
        p_res_data = sqrt_of[order[1]];
        #1;
        check("release_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        check("pushpop_infl", 32'(inflight), 32'h7);
        check("pushpop_rsp", 32'(rsp_valid), 32'(1 << order[1]));
        check("pushpop_pval", 32'(p_valid), 32'h1);
        check("pushpop_pdata", 32'(p_data), 32'(op_of[2]));
        for (int k = 0; k < 7; k++) begin
            p_res_data = sqrt_of[rest[k]];
            tick();
            check($sformatf("drain_val%0d", k), 32'(rsp_valid), 32'(1 << rest[k]));
            check($sformatf("drain_data%0d", k), 32'(rsp_data), 32'(sqrt_of[rest[k]]));
        end
        p_res_valid = 1'b0;
        check("drain_infl", 32'(inflight), 32'h0);

        // Idle timeout
        repeat (15) tick();
        check("idle15_pen", 32'(p_enable), 32'h1);
        tick();
        check("idle16_pen", 32'(p_enable), 32'h0);
        req_valid = 4'b0001;
        tick();
        check("rewake_pen", 32'(p_enable), 32'h1);
        check("rewake_ready", 32'(req_ready), 32'h0);
        tick();
        check("rerun_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("reissue_pdata", 32'(p_data), 32'h3C00);
        check("reissue_infl", 32'(inflight), 32'h1);

        // Underflow
        p_res_valid = 1'b1; p_res_data = 16'h3C00;
        tick();
        check("last_rsp", 32'(rsp_valid), 32'h1);
        check("last_err", 32'(err_underflow), 32'h0);
        p_res_data = 16'h1234;
        tick();
        p_res_valid = 1'b0;
        check("uf_rsp", 32'(rsp_valid), 32'h0);
        check("uf_err", 32'(err_underflow), 32'h1);
        check("uf_rdata", 32'(rsp_data), 32'h3C00);
        check("uf_infl", 32'(inflight), 32'h0);

        // Reset mid-traffic
        req_valid = 4'hF;
        tick();
        check("mid_infl1", 32'(inflight), 32'h1);
        tick();
        check("mid_infl2", 32'(inflight), 32'h2);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        tick();
        req_valid = '0;
        rst = 1'b0;
        tick();
        p_res_valid = 1'b1; p_res_data = 16'h4000;
        tick();
        p_res_valid = 1'b0;
        check("post_rsp", 32'(rsp_valid), 32'h0);
        check("post_err", 32'(err_underflow), 32'h1);
        check("post_infl", 32'(inflight), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
